mult_div_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit: iterative radix-2 multiply / restoring divide with HI/LO regs
// Revision: 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d, a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic               is_div_q, is_div_d, dbz_q, dbz_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_out_q, dbz_out_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+2:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign signed_op = SIGNED_EN && (op == 3'd0 || op == 3'd2);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  // Low half of acc holds the remaining multiplier bits (MUL) or the
  // dividend-turning-quotient (DIV); both shift one position per cycle.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_diff = {1'b0, rem_q, acc_q[WIDTH-1]} - {3'b000, opb_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              cnt_d     = '0;
              rem_d     = '0;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              is_div_d  = op[1];
              dbz_d     = (b == '0);
              a_raw_d   = a;
              if (op[1]) begin
                acc_d   = {{WIDTH{1'b0}}, a_abs};
                opb_d   = b_abs;
                state_d = S_DIV;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, b_abs};
                opb_d   = a_abs;
                state_d = S_MUL;
              end
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[WIDTH+2]) begin
          rem_d              = div_diff[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d              = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      default: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dbz_q) begin
          lo_d      = '1;
          hi_d      = a_raw_q;
          dbz_out_d = 1'b1;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // An abort anywhere in the op, FIX included, discards the result.
    if (flush && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit: directed + randomized bench for mult_div_unit with an
// arithmetic reference model. Revision: 1.0
// ============================================================================
module tb_mult_div_unit;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              flush = 1'b0;
  logic [2:0]        op = 3'd7;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              busy, done, div_by_zero;
  logic [WIDTH-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference state: what the outputs must show after each edge.
  bit               m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  mult_div_unit #(.WIDTH(WIDTH), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic definition of every MULT/DIV result.
  function automatic void ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output bit rd);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] pr, q, r;
    bit sg;
    sg = (o == 3'd0 || o == 3'd2);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rd = 1'b0;
    if (o < 3'd2) begin
      if (sg) pr = sx * sy;
      else    pr = ux * uy;
      rh = pr[63:32];
      rl = pr[31:0];
    end else if (y == 32'd0) begin
      rl = '1;
      rh = x;
      rd = 1'b1;
    end else if (sg) begin
      q  = sx / sy;
      r  = sx % sy;
      rl = q[31:0];
      rh = r[31:0];
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] rh, rl;
    bit rd;
    if (rst) begin
      m_busy <= 1'b0; m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dbz <= p_dbz;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        if (op < 3'd4) begin
          ref_result(op, a, b, rh, rl, rd);
          p_hi <= rh; p_lo <= rl; p_dbz <= rd;
          m_busy <= 1'b1;
          m_left <= WIDTH + 1;
        end else if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("done", {63'd0, done}, {63'd0, m_done});
      if (m_done) check("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    int n;
    bc = 0;
    n  = 0;
    while (!done && n < 80) begin
      if (busy) bc++;
      n++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      4:       return 32'(-($urandom % 16));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check("t1_busy_cycles", 64'(bc), 64'd33);
    check("t1_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("t1_lo", {32'd0, lo}, 64'h0000_0001);

    issue(3'd0, -32'd3, 32'd5);
    wait_done(bc);
    check("t2_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("t2_lo", {32'd0, lo}, 64'hFFFF_FFF1);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("t2_b2b_lo", {32'd0, lo}, 64'd42);

    issue(3'd2, -32'd7, 32'd2);
    wait_done(bc);
    check("t3_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("t3_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    check("t3_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("t3_ovf_hi", {32'd0, hi}, 64'd0);
    check("t3_ovf_dbz", {63'd0, div_by_zero}, 64'd0);

    issue(3'd3, 32'd10, 32'd0);
    wait_done(bc);
    check("t4_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("t4_hi", {32'd0, hi}, 64'h0000_000A);
    check("t4_dbz", {63'd0, div_by_zero}, 64'd1);

    do_reset();
    issue(3'd4, 32'h1234, 32'd0);
    check("t5_mthi", {32'd0, hi}, 64'h1234);
    issue(3'd0, 32'd2, 32'd3);
    for (int k = 1; k < 10; k++) begin
      start = (k == 3); op = 3'd5; a = 32'hDEAD;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_busy_after_flush", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("t5_hi", {32'd0, hi}, 64'h1234);
    check("t5_lo", {32'd0, lo}, 64'd0);

    // Flush coinciding with start in IDLE drops the op.
    start = 1'b1; flush = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {63'd0, busy}, 64'd0);

    do_reset();
    issue(3'd3, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_hi", {32'd0, hi}, 64'd0);
    check("t6_lo", {32'd0, lo}, 64'd0);
    issue(3'd3, 32'd100, 32'd7);
    wait_done(bc);
    check("t6_lo_q", {32'd0, lo}, 64'd14);
    check("t6_hi_r", {32'd0, hi}, 64'd2);

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      op    = 3'($urandom % 8);
      a     = pick();
      b     = pick();
      start = m_busy ? ($urandom % 8 == 0) : ($urandom % 3 == 0);
      flush = ($urandom % 40 == 0);
      if (!m_busy && start && op >= 3'd4) flush = 1'b0;
      rst   = ($urandom % 700 == 0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
